// File: rtl/lru_victim_select.sv
// Victim-way selector for a set-associative cache: round-robin scan of per-way
// LRU flags, a held offer until the fill is acknowledged, and tracker touch strobes.
module lru_victim_select #(
  parameter int WAYS  = 4,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WAYS-1:0]  lru_i,
  input  logic             hit_valid,
  input  logic [IDX_W-1:0] hit_way,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic             victim_valid,
  output logic [IDX_W-1:0] victim_way,
  input  logic             victim_ack,
  output logic             trk_en,
  output logic [WAYS-1:0]  trk_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] victim_way_q, victim_way_d;
  logic             ack_s;

  // First set LRU flag at or after ptr, wrapping; falls back to ptr when none is set.
  function automatic logic [IDX_W-1:0] find_victim(input logic [WAYS-1:0]  lru,
                                                   input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    find_victim = ptr;
    found       = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && lru[idx]) begin
        find_victim = idx;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  assign ack_s = (state_q == OFFER) && victim_ack;

  // State, round-robin pointer and victim registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      victim_way_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      victim_way_q <= victim_way_d;
    end
  end

  // Next-state logic: the victim is captured only in SCAN and frozen through OFFER.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    victim_way_d = victim_way_q;
    case (state_q)
      IDLE: begin
        if (alloc_req) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        victim_way_d = find_victim(lru_i, rr_ptr_q);
        state_d      = OFFER;
      end
      OFFER: begin
        if (victim_ack) begin
          rr_ptr_d = victim_way_q + IDX_W'(1);
          state_d  = IDLE;
        end else begin
          state_d = OFFER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tracker touch: OR of the hit way and the acknowledged victim way.
  always_comb begin
    trk_active = '0;
    if (hit_valid && !rst) begin
      trk_active[hit_way] = 1'b1;
    end else begin
      trk_active = trk_active;
    end
    if (ack_s) begin
      trk_active[victim_way_q] = 1'b1;
    end else begin
      trk_active = trk_active;
    end
    trk_en = |trk_active;
  end

  assign alloc_ready  = (state_q == IDLE);
  assign victim_valid = (state_q == OFFER);
  assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_lru_victim_select.sv
// Self-checking bench for lru_victim_select: directed scenarios followed by
// randomized allocations, checked against a modulo-arithmetic victim model.
module tb_lru_victim_select;

  localparam int WAYS  = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WAYS-1:0]  lru_i;
  logic             hit_valid;
  logic [IDX_W-1:0] hit_way;
  logic             alloc_req;
  logic             alloc_ready;
  logic             victim_valid;
  logic [IDX_W-1:0] victim_way;
  logic             victim_ack;
  logic             trk_en;
  logic [WAYS-1:0]  trk_active;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int m_rr   = 0;

  lru_victim_select #(.WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .lru_i(lru_i), .hit_valid(hit_valid), .hit_way(hit_way),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .victim_valid(victim_valid),
    .victim_way(victim_way), .victim_ack(victim_ack), .trk_en(trk_en),
    .trk_active(trk_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first way with its flag set walking rr, rr+1, ... modulo WAYS.
  function automatic int ref_victim(input logic [WAYS-1:0] lru, input int rr);
    for (int k = 0; k < WAYS; k++) begin
      if (lru[(rr + k) % WAYS]) return (rr + k) % WAYS;
    end
    return rr;
  endfunction

  function automatic int onehot(input int w);
    return 1 << w;
  endfunction

  task automatic do_alloc(input logic [WAYS-1:0] lru, input int delay, input bit toggle,
                          input bit ack_hit, input int ack_hw);
    int exp_w;
    int exp_act;
    exp_w = ref_victim(lru, m_rr);
    chk("idle_ready", 32'(alloc_ready), 32'd1);
    chk("idle_valid", 32'(victim_valid), 32'd0);
    victim_ack = 1'b1;
    #1;
    chk("idle_ack_ignored", 32'(trk_en), 32'd0);
    victim_ack = 1'b0;
    lru_i      = lru;
    alloc_req  = 1'b1;
    @(posedge clk); #1;
    alloc_req = 1'b0;
    chk("scan_ready", 32'(alloc_ready), 32'd0);
    chk("scan_valid", 32'(victim_valid), 32'd0);
    @(posedge clk); #1;
    chk("offer_valid", 32'(victim_valid), 32'd1);
    chk("offer_way", 32'(victim_way), 32'(exp_w));
    chk("offer_ready", 32'(alloc_ready), 32'd0);
    for (int d = 0; d < delay; d++) begin
      lru_i     = toggle ? ~lru_i : 4'($urandom);
      alloc_req = 1'($urandom_range(0, 1));
      hit_valid = 1'($urandom_range(0, 1));
      hit_way   = 2'($urandom_range(0, WAYS - 1));
      #1;
      chk("hold_trk_active", 32'(trk_active), hit_valid ? 32'(onehot(int'(hit_way))) : 32'd0);
      chk("hold_trk_en", 32'(trk_en), 32'(hit_valid));
      @(posedge clk); #1;
      chk("hold_valid", 32'(victim_valid), 32'd1);
      chk("hold_way", 32'(victim_way), 32'(exp_w));
    end
    alloc_req  = 1'b0;
    hit_valid  = ack_hit;
    hit_way    = 2'(ack_hw);
    victim_ack = 1'b1;
    #1;
    exp_act = onehot(exp_w) | (ack_hit ? onehot(ack_hw) : 0);
    chk("ack_trk_en", 32'(trk_en), 32'd1);
    chk("ack_trk_active", 32'(trk_active), 32'(exp_act));
    @(posedge clk); #1;
    victim_ack = 1'b0;
    hit_valid  = 1'b0;
    m_rr       = (exp_w + 1) % WAYS;
    #1;
    chk("post_ack_ready", 32'(alloc_ready), 32'd1);
    chk("post_ack_valid", 32'(victim_valid), 32'd0);
    chk("post_ack_trk_en", 32'(trk_en), 32'd0);
    chk("post_ack_trk_active", 32'(trk_active), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(victim_valid), 32'd0);
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_way", 32'(victim_way), 32'd0);
    chk("rst_trk_en", 32'(trk_en), 32'd0);
    chk("rst_trk_active", 32'(trk_active), 32'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    m_rr = 0;
  endtask

  initial begin
    rst        = 1'b1;
    lru_i      = 4'b0000;
    hit_valid  = 1'b0;
    hit_way    = 2'd0;
    alloc_req  = 1'b0;
    victim_ack = 1'b0;

    apply_reset();
    // Single victim at way 2, then wrap search from rr=3.
    do_alloc(4'b0100, 0, 1'b0, 1'b0, 0);
    do_alloc(4'b0011, 0, 1'b0, 1'b0, 0);
    // Empty flags walk the round-robin pointer.
    apply_reset();
    do_alloc(4'b0000, 0, 1'b0, 1'b0, 0);
    do_alloc(4'b0000, 0, 1'b0, 1'b0, 0);
    // Victim 2 with a same-cycle hit on way 1, then hit on the victim itself.
    do_alloc(4'b0000, 0, 1'b0, 1'b1, 1);
    do_alloc(4'b1000, 0, 1'b0, 1'b1, 3);
    // Long hold with toggling flags and ignored alloc_req pulses.
    do_alloc(4'b0010, 5, 1'b1, 1'b0, 0);

    // Reset mid-offer aborts without a tracker touch.
    lru_i     = 4'b0100;
    alloc_req = 1'b1;
    @(posedge clk); #1;
    alloc_req = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_valid", 32'(victim_valid), 32'd1);
    victim_ack = 1'b1;
    rst        = 1'b1;
    #1;
    chk("abort_valid", 32'(victim_valid), 32'd0);
    chk("abort_ready", 32'(alloc_ready), 32'd1);
    chk("abort_trk_en", 32'(trk_en), 32'd0);
    victim_ack = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
    m_rr = 0;
    do_alloc(4'b0000, 0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      do_alloc(4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, WAYS - 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
